rd73_frame_accum: RTL

//  Downstream consumer of the 7-input ones-count stage.
//  - Accepts one 3-bit count (0..7) per beat over a valid/ready handshake.
//  - Accumulates FRAME_LEN beats, or fewer if flushed, into a frame total.
//  - Tracks the per-frame maximum and compares the total against THRESH.
//  - Presents the frame result on a registered valid/ready output port.

---
 rtl/rd73_frame_accum_if.sv | 28 ++
 rtl/rd73_frame_accum.sv | 119 +++++++++++
 2 files changed

// File: rtl/rd73_frame_accum_if.sv
// Stream bundle for the frame accumulator: per-beat count input on one side,
// per-frame result output on the other, each with its own valid/ready pair.
interface rd73_frame_accum_if #(
    parameter int SUM_W = 7
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_count;
    logic             in_flush;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sum;
    logic [2:0]       out_max;
    logic [7:0]       out_beats;
    logic             out_over;

    // The accumulator itself: consumes counts, produces frame results.
    modport slave (
        input  in_valid, in_count, in_flush, out_ready,
        output in_ready, out_valid, out_sum, out_max, out_beats, out_over
    );

    // The surrounding logic: produces counts, consumes frame results.
    modport master (
        output in_valid, in_count, in_flush, out_ready,
        input  in_ready, out_valid, out_sum, out_max, out_beats, out_over
    );
endinterface

// File: rtl/rd73_frame_accum.sv
// Frame accumulator behind the 7-input ones-count stage. Sums up to FRAME_LEN
// 3-bit counts (or fewer when a beat carries in_flush), tracks the largest
// count seen, flags totals at or above THRESH and holds the frame result on
// the output port until the downstream side takes it.
module rd73_frame_accum #(
    parameter int FRAME_LEN = 16,
    parameter int SUM_W     = 7,
    parameter int THRESH    = 56
) (
    input  logic            clk,
    input  logic            rst,
    rd73_frame_accum_if.slave bus
);
    localparam logic [7:0]       LAST_BEAT = 8'(FRAME_LEN - 1);
    localparam logic [SUM_W-1:0] THRESH_V  = SUM_W'(THRESH);

    generate
        if (FRAME_LEN < 2 || FRAME_LEN > 255) begin : g_bad_frame_len
            $error("rd73_frame_accum: FRAME_LEN must be in 2..255");
        end
        if (7 * FRAME_LEN > 2 ** SUM_W - 1) begin : g_bad_sum_w
            $error("rd73_frame_accum: SUM_W too narrow for 7*FRAME_LEN");
        end
    endgenerate

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] sum_new;
    logic [2:0]       max_q;
    logic [2:0]       max_new;
    logic [7:0]       beat_cnt;
    logic             accept;
    logic             close;
    logic [SUM_W-1:0] out_sum_q;
    logic [2:0]       out_max_q;
    logic [7:0]       out_beats_q;
    logic             out_over_q;

    // Handshake decode and next state; the running totals including the
    // current beat are formed here so a closing beat lands in the result.
    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        accept        = 1'b0;
        close         = 1'b0;
        sum_new       = acc + SUM_W'(bus.in_count);
        max_new       = (bus.in_count > max_q) ? bus.in_count : max_q;
        case (state)
            ACCUM: begin
                bus.in_ready = 1'b1;
                accept       = bus.in_valid;
                close        = accept & ((beat_cnt == LAST_BEAT) | bus.in_flush);
                if (close) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    // State register; a reset anywhere drops the frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Running frame totals, cleared as soon as a frame closes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            max_q    <= '0;
            beat_cnt <= '0;
        end else if (close) begin
            acc      <= '0;
            max_q    <= '0;
            beat_cnt <= '0;
        end else if (accept) begin
            acc      <= sum_new;
            max_q    <= max_new;
            beat_cnt <= beat_cnt + 8'd1;
        end
    end

    // Result registers load only on the closing beat and stay put through HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_sum_q   <= '0;
            out_max_q   <= '0;
            out_beats_q <= '0;
            out_over_q  <= 1'b0;
        end else if (close) begin
            out_sum_q   <= sum_new;
            out_max_q   <= max_new;
            out_beats_q <= beat_cnt + 8'd1;
            out_over_q  <= (sum_new >= THRESH_V);
        end
    end

    assign bus.out_sum   = out_sum_q;
    assign bus.out_max   = out_max_q;
    assign bus.out_beats = out_beats_q;
    assign bus.out_over  = out_over_q;
endmodule
